// File: rtl/spart_host_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spart_host_pkg : shared types and constants for the SPART host driver      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package spart_host_pkg;

   typedef enum logic [1:0] {
      TX_IDLE   = 2'd0,
      TX_STROBE = 2'd1,
      TX_GAP    = 2'd2,
      TX_BUSY   = 2'd3
   } tx_state_t;

   localparam int DEFAULT_DIVISOR = 326;
   localparam int TX_GAP_CYCLES   = 2;

endpackage
`default_nettype wire

// File: rtl/spart_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spart_sync_fifo : single-clock FIFO, DEPTH a power of two, head on dout    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module spart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/spart_host_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spart_host_driver : host-side SPART master (TX/RX FIFOs, strobe FSM, baud) |
// | Optional macro SPART_HOST_ECHO_EN adds a one-entry rx->tx echo slot.       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module spart_host_driver
   import spart_host_pkg::*;
#(
   parameter int DIVISOR    = DEFAULT_DIVISOR,
   parameter int FIFO_DEPTH = 8,
   parameter int TX_TIMEOUT = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_push,
   input  logic [7:0] tx_byte,
   output logic       tx_full,
   input  logic       rx_pop,
   output logic [7:0] rx_byte,
   output logic       rx_empty,
   output logic       rx_overrun,
   output logic       tx_timeout,
   output logic       baud_en,
   output logic       iorw,
   output logic [7:0] databus,
   input  logic       rda,
   input  logic       tbr,
   input  logic [7:0] rx_data
);
   localparam int BW = $clog2(DIVISOR);
   localparam int TW = $clog2(TX_TIMEOUT + 1);
   localparam logic [BW-1:0] BAUD_LAST    = BW'(DIVISOR - 1);
   localparam logic [TW-1:0] GAP_LAST     = TW'(TX_GAP_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TX_TIMEOUT - 1);

   logic [BW-1:0] baud_cnt;
   tx_state_t     state, next_state;
   logic [TW-1:0] cnt, cnt_d;
   logic          iorw_d, load, tx_pop, timeout_set, issue;
   logic [7:0]    tx_head, tx_next;
   logic          tx_empty, rx_full, rda_q, capture;
   logic          echo_valid;
   logic [7:0]    echo_byte;

   always_ff @(posedge clk) begin
      if (rst)                       baud_cnt <= '0;
      else if (baud_cnt == BAUD_LAST) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + BW'(1);
   end
   assign baud_en = (baud_cnt == BAUD_LAST);

   spart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push), .din(tx_byte), .full(tx_full),
      .pop(tx_pop), .dout(tx_head), .empty(tx_empty)
   );

   spart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(capture), .din(rx_data), .full(rx_full),
      .pop(rx_pop), .dout(rx_byte), .empty(rx_empty)
   );

   assign capture = rda & ~rda_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rda_q      <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         rda_q <= rda;
         if (capture & rx_full & ~rx_pop) rx_overrun <= 1'b1;
      end
   end

`ifdef SPART_HOST_ECHO_EN
   // A fresh capture wins over the slot being drained in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         echo_valid <= 1'b0;
         echo_byte  <= 8'h00;
      end else if (capture) begin
         echo_valid <= 1'b1;
         echo_byte  <= rx_data;
      end else if (load & echo_valid) begin
         echo_valid <= 1'b0;
      end
   end
`else
   assign echo_valid = 1'b0;
   assign echo_byte  = 8'h00;
`endif

   assign issue   = tbr & (echo_valid | ~tx_empty);
   assign tx_next = echo_valid ? echo_byte : tx_head;

   always_ff @(posedge clk) begin
      if (rst) state <= TX_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         TX_IDLE:   if (issue) next_state = TX_STROBE;
         TX_STROBE: next_state = TX_GAP;
         TX_GAP:    if (cnt == GAP_LAST) next_state = TX_BUSY;
         TX_BUSY:   if (tbr || (cnt == TIMEOUT_LAST)) next_state = TX_IDLE;
         default:   next_state = TX_IDLE;
      endcase
   end

   always_comb begin
      iorw_d      = 1'b1;
      load        = 1'b0;
      tx_pop      = 1'b0;
      cnt_d       = cnt;
      timeout_set = 1'b0;
      case (state)
         TX_IDLE: begin
            if (issue) begin
               iorw_d = 1'b0;
               load   = 1'b1;
               tx_pop = ~echo_valid;
               cnt_d  = '0;
            end
         end
         TX_STROBE: cnt_d = '0;
         TX_GAP:    cnt_d = (cnt == GAP_LAST) ? '0 : cnt + TW'(1);
         TX_BUSY: begin
            cnt_d       = cnt + TW'(1);
            timeout_set = ~tbr & (cnt == TIMEOUT_LAST);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         iorw       <= 1'b1;
         databus    <= 8'h00;
         cnt        <= '0;
         tx_timeout <= 1'b0;
      end else begin
         iorw <= iorw_d;
         cnt  <= cnt_d;
         if (load)        databus    <= tx_next;
         if (timeout_set) tx_timeout <= 1'b1;
      end
   end

endmodule
`default_nettype wire
